// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard / exception control for a five-stage Y86-style pipeline.
// Derives stall and bubble controls from the decode, execute and memory
// stages. A two-state FSM (RUN / HALTED) stops the pipeline when a
// writeback-stage exception retires.
// Optional feature: define PIPE_CTRL_PERF_CNT_EN to add the saturating
// hazard counters lu_cnt, mp_cnt and ret_cnt.
module pipe_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  D_icode,
    input  logic [3:0]  d_srcA,
    input  logic [3:0]  d_srcB,
    input  logic [3:0]  E_icode,
    input  logic [3:0]  E_destM,
    input  logic        e_Cnd,
    input  logic [3:0]  M_icode,
    input  logic [1:0]  m_status,
    input  logic [1:0]  W_status,
    output logic        F_stall,
    output logic        D_stall,
    output logic        W_stall,
    output logic        D_bubble,
    output logic        E_bubble,
    output logic        M_bubble,
    output logic        halted,
    output logic [1:0]  halt_code,
    output logic [31:0] cycle_cnt
`ifdef PIPE_CTRL_PERF_CNT_EN
    ,
    output logic [31:0] lu_cnt,
    output logic [31:0] mp_cnt,
    output logic [31:0] ret_cnt
`endif
);

    localparam logic [3:0] IC_MRMOVQ = 4'h5;
    localparam logic [3:0] IC_JXX    = 4'h7;
    localparam logic [3:0] IC_RET    = 4'h9;
    localparam logic [3:0] IC_POPQ   = 4'hB;
    localparam logic [3:0] REG_NONE  = 4'hF;
    localparam logic [1:0] ST_HLT    = 2'b01;
    localparam logic [1:0] ST_ERR    = 2'b10;

    typedef enum logic [0:0] {
        S_RUN    = 1'b0,
        S_HALTED = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_load_use;
    logic        w_mispredict;
    logic        w_ret_pend;
    logic        w_exc_m;
    logic        w_exc_w;
    logic        w_run_eq;
    logic [1:0]  r_halt_code;
    logic [31:0] r_cycle_cnt;

    // Hazard and exception decode from the stage pipeline registers.
    always_comb begin
        w_load_use   = 1'b0;
        w_mispredict = 1'b0;
        w_ret_pend   = 1'b0;
        w_exc_m      = 1'b0;
        w_exc_w      = 1'b0;
        if (((E_icode == IC_MRMOVQ) || (E_icode == IC_POPQ)) && (E_destM != REG_NONE) &&
            ((E_destM == d_srcA) || (E_destM == d_srcB))) begin
            w_load_use = 1'b1;
        end else begin
            w_load_use = 1'b0;
        end
        w_mispredict = (E_icode == IC_JXX) && !e_Cnd;
        w_ret_pend   = (D_icode == IC_RET) || (E_icode == IC_RET) || (M_icode == IC_RET);
        // Bubble status (11) counts as AOK, so only HLT and error raise exceptions.
        w_exc_m      = (m_status == ST_HLT) || (m_status == ST_ERR);
        w_exc_w      = (W_status == ST_HLT) || (W_status == ST_ERR);
    end

    // State register; reset always returns to RUN, even from HALTED.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and stage controls; reset forces the RUN equations.
    always_comb begin
        w_state_nxt = r_state;
        F_stall     = 1'b0;
        D_stall     = 1'b0;
        W_stall     = 1'b0;
        D_bubble    = 1'b0;
        E_bubble    = 1'b0;
        M_bubble    = 1'b0;
        w_run_eq    = rst || (r_state == S_RUN);
        case (r_state)
            S_RUN: begin
                if (w_exc_w) begin
                    w_state_nxt = S_HALTED;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_HALTED: w_state_nxt = S_HALTED;
            default:  w_state_nxt = S_RUN;
        endcase
        if (w_run_eq) begin
            F_stall  = w_load_use | w_ret_pend;
            D_stall  = w_load_use;
            // A load-use stall in decode wins over the ret bubble.
            D_bubble = w_mispredict | (w_ret_pend & ~w_load_use);
            E_bubble = w_mispredict | w_load_use;
            M_bubble = w_exc_m | w_exc_w;
            W_stall  = w_exc_w;
        end else begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            W_stall  = 1'b1;
            D_bubble = 1'b0;
            E_bubble = 1'b0;
            M_bubble = 1'b1;
        end
    end

    // Capture the retiring status on the halting edge and hold it afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_halt_code <= 2'b00;
        end else if ((r_state == S_RUN) && w_exc_w) begin
            r_halt_code <= W_status;
        end else begin
            r_halt_code <= r_halt_code;
        end
    end

    // Free-running RUN cycle counter, wraps naturally, frozen once halted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle_cnt <= 32'h0000_0000;
        end else if (r_state == S_RUN) begin
            r_cycle_cnt <= r_cycle_cnt + 32'h0000_0001;
        end else begin
            r_cycle_cnt <= r_cycle_cnt;
        end
    end

    assign halted    = (r_state == S_HALTED);
    assign halt_code = r_halt_code;
    assign cycle_cnt = r_cycle_cnt;

`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [31:0] r_lu_cnt;
    logic [31:0] r_mp_cnt;
    logic [31:0] r_ret_cnt;

    // Saturating per-hazard event counters, active only in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lu_cnt  <= 32'h0000_0000;
            r_mp_cnt  <= 32'h0000_0000;
            r_ret_cnt <= 32'h0000_0000;
        end else if (r_state == S_RUN) begin
            if (w_load_use && (r_lu_cnt != 32'hFFFF_FFFF)) begin
                r_lu_cnt <= r_lu_cnt + 32'h0000_0001;
            end else begin
                r_lu_cnt <= r_lu_cnt;
            end
            if (w_mispredict && (r_mp_cnt != 32'hFFFF_FFFF)) begin
                r_mp_cnt <= r_mp_cnt + 32'h0000_0001;
            end else begin
                r_mp_cnt <= r_mp_cnt;
            end
            if (w_ret_pend && !w_load_use && (r_ret_cnt != 32'hFFFF_FFFF)) begin
                r_ret_cnt <= r_ret_cnt + 32'h0000_0001;
            end else begin
                r_ret_cnt <= r_ret_cnt;
            end
        end else begin
            r_lu_cnt  <= r_lu_cnt;
            r_mp_cnt  <= r_mp_cnt;
            r_ret_cnt <= r_ret_cnt;
        end
    end

    assign lu_cnt  = r_lu_cnt;
    assign mp_cnt  = r_mp_cnt;
    assign ret_cnt = r_ret_cnt;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl. A driver applies directed
// and random vectors and pushes the reference-model response into a queue;
// a monitor samples the DUT each cycle and compares against the queue.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_PERF_CNT_EN
    localparam int EW = 41 + 96;
`else
    localparam int EW = 41;
`endif

    logic        clk;
    logic        rst;
    logic [3:0]  D_icode, d_srcA, d_srcB, E_icode, E_destM, M_icode;
    logic        e_Cnd;
    logic [1:0]  m_status, W_status;
    logic        F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, halted;
    logic [1:0]  halt_code;
    logic [31:0] cycle_cnt;
`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [31:0] lu_cnt, mp_cnt, ret_cnt;
`endif

    pipe_ctrl dut (
        .clk(clk), .rst(rst), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_destM(E_destM), .e_Cnd(e_Cnd), .M_icode(M_icode),
        .m_status(m_status), .W_status(W_status),
        .F_stall(F_stall), .D_stall(D_stall), .W_stall(W_stall),
        .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble),
        .halted(halted), .halt_code(halt_code), .cycle_cnt(cycle_cnt)
`ifdef PIPE_CTRL_PERF_CNT_EN
        , .lu_cnt(lu_cnt), .mp_cnt(mp_cnt), .ret_cnt(ret_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [EW-1:0] exp;
        string         tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model architectural state
    bit          m_halted = 1'b0;
    bit [1:0]    m_code   = 2'b00;
    bit [31:0]   m_cyc    = 32'd0;
    bit [31:0]   m_lu     = 32'd0;
    bit [31:0]   m_mp     = 32'd0;
    bit [31:0]   m_ret    = 32'd0;

    function automatic bit [31:0] sat_inc(input bit [31:0] v, input bit en);
        if (en && v != 32'hFFFF_FFFF) return v + 32'd1;
        return v;
    endfunction

    // Apply one vector at the falling edge, predict the response, advance the model.
    task automatic drive(input logic rv, input logic [3:0] di, input logic [3:0] sa,
                         input logic [3:0] sb, input logic [3:0] ei, input logic [3:0] ed,
                         input logic cnd, input logic [3:0] mi, input logic [1:0] ms,
                         input logic [1:0] ws, input string tag);
        bit lu, mp, rp, exm, exw;
        bit fs, ds, wst, db, eb, mb;
        exp_t e;
        @(negedge clk);
        rst = rv; D_icode = di; d_srcA = sa; d_srcB = sb; E_icode = ei; E_destM = ed;
        e_Cnd = cnd; M_icode = mi; m_status = ms; W_status = ws;
        #1;
        lu  = (ei inside {4'h5, 4'hB}) && ed != 4'hF && (ed == sa || ed == sb);
        mp  = (ei == 4'h7) && !cnd;
        rp  = (di == 4'h9) || (ei == 4'h9) || (mi == 4'h9);
        exm = (ms == 2'b01) || (ms == 2'b10);
        exw = (ws == 2'b01) || (ws == 2'b10);
        if (!m_halted || rv) begin
            fs = lu || rp; ds = lu; db = mp || (rp && !lu); eb = mp || lu;
            mb = exm || exw; wst = exw;
        end else begin
            fs = 1'b1; ds = 1'b1; wst = 1'b1; db = 1'b0; eb = 1'b0; mb = 1'b1;
        end
        e.exp = {fs, ds, wst, db, eb, mb, m_halted, m_code, m_cyc
`ifdef PIPE_CTRL_PERF_CNT_EN
                 , m_lu, m_mp, m_ret
`endif
                };
        e.tag = tag;
        sb_q.push_back(e);
        // State after the coming rising edge
        if (rv) begin
            m_halted = 1'b0; m_code = 2'b00; m_cyc = 32'd0;
            m_lu = 32'd0; m_mp = 32'd0; m_ret = 32'd0;
        end else if (!m_halted) begin
            m_cyc = m_cyc + 32'd1;
            m_lu  = sat_inc(m_lu, lu);
            m_mp  = sat_inc(m_mp, mp);
            m_ret = sat_inc(m_ret, rp && !lu);
            if (exw) begin
                m_halted = 1'b1;
                m_code   = ws;
            end
        end
    endtask

    task automatic nop(input logic rv, input string tag);
        drive(rv, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 2'b00, 2'b00, tag);
    endtask

    function automatic logic [3:0] pick_icode();
        logic [3:0] tbl [0:5];
        tbl[0] = 4'h0; tbl[1] = 4'h1; tbl[2] = 4'h5; tbl[3] = 4'h7; tbl[4] = 4'h9; tbl[5] = 4'hB;
        if ($urandom_range(0, 4) == 0) return 4'($urandom_range(0, 15));
        return tbl[$urandom_range(0, 5)];
    endfunction

    // Monitor: sample every cycle after the driver settles and check queued expectations.
    initial begin
        logic [EW-1:0] act;
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                act = {F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, halted,
                       halt_code, cycle_cnt
`ifdef PIPE_CTRL_PERF_CNT_EN
                       , lu_cnt, mp_cnt, ret_cnt
`endif
                      };
                n_vec++;
                if (act !== e.exp) begin
                    n_err++;
                    $display("FAIL %s vec=%0d got=%h exp=%h", e.tag, n_vec, act, e.exp);
                end
            end
        end
    end

    initial begin
        int hcnt;
        rst = 1'b1; D_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF; E_icode = 4'h1;
        E_destM = 4'hF; e_Cnd = 1'b1; M_icode = 4'h1; m_status = 2'b00; W_status = 2'b00;
        repeat (2) @(posedge clk);

        nop(1'b1, "reset_state");
        nop(1'b1, "reset_state2");
        // Load-use on srcA and srcB, and POPQ, plus destM=F non-hazard
        drive(1'b0, 4'h1, 4'h3, 4'hF, 4'h5, 4'h3, 1'b1, 4'h1, 2'b00, 2'b00, "load_use_a");
        drive(1'b0, 4'h1, 4'hF, 4'h6, 4'hB, 4'h6, 1'b1, 4'h1, 2'b00, 2'b00, "load_use_b");
        drive(1'b0, 4'h1, 4'hF, 4'hF, 4'h5, 4'hF, 1'b1, 4'h1, 2'b00, 2'b00, "destm_none");
        // Branch mispredict and correctly predicted branch
        drive(1'b0, 4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 1'b0, 4'h1, 2'b00, 2'b00, "mispredict");
        drive(1'b0, 4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 1'b1, 4'h1, 2'b00, 2'b00, "jxx_taken");
        // Ret pending three cycles, then ret combined with load-use
        for (int i = 0; i < 3; i++)
            drive(1'b0, 4'h9, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 2'b00, 2'b00, "ret_pend");
        drive(1'b0, 4'h9, 4'h2, 4'hF, 4'h5, 4'h2, 1'b1, 4'h1, 2'b00, 2'b00, "ret_load_use");
        drive(1'b0, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h9, 2'b00, 2'b00, "ret_in_m");
        // Memory error with bubble writeback, then bubble status alone
        drive(1'b0, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 2'b10, 2'b11, "exc_m_only");
        for (int i = 0; i < 3; i++)
            drive(1'b0, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 2'b11, 2'b11, "bubble_status");
        // Halt after a fresh reset, hold, then clear with reset
        nop(1'b1, "pre_halt_rst");
        for (int i = 0; i < 9; i++) nop(1'b0, "pre_halt");
        drive(1'b0, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 2'b00, 2'b01, "halt_edge");
        for (int i = 0; i < 3; i++)
            drive(1'b0, 4'h9, 4'h3, 4'hF, 4'h7, 4'h3, 1'b0, 4'h1, 2'b10, 2'b10, "halted_hold");
        drive(1'b1, 4'h9, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 2'b00, 2'b10, "rst_from_halt");
        nop(1'b0, "after_rst");
        // Error-status halt with simultaneous reset (reset wins)
        drive(1'b1, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 2'b00, 2'b10, "rst_vs_exc");
        drive(1'b0, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 2'b00, 2'b10, "halt_err");
        nop(1'b0, "halted_err");

        // Random traffic with occasional exceptions and resets
        hcnt = 0;
        for (int i = 0; i < 600; i++) begin
            logic [3:0] di, ei, ed, sa, sb;
            logic [1:0] ws;
            logic rv;
            di = pick_icode(); ei = pick_icode();
            ed = 4'($urandom_range(0, 5)); if ($urandom_range(0, 5) == 0) ed = 4'hF;
            sa = 4'($urandom_range(0, 5)); if ($urandom_range(0, 3) == 0) sa = 4'hF;
            sb = 4'($urandom_range(0, 5)); if ($urandom_range(0, 3) == 0) sb = 4'hF;
            ws = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
            if ($urandom_range(0, 39) == 0) ws = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            hcnt = m_halted ? hcnt + 1 : 0;
            rv = ($urandom_range(0, 59) == 0) || (hcnt > 6);
            drive(rv, di, sa, sb, ei, ed, 1'($urandom_range(0, 1)), pick_icode(),
                  2'($urandom_range(0, 3)), ws, "random");
        end

        repeat (3) @(negedge clk);
        #3;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain pending=%0d expected=0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
